// File: rtl/finalproject_pkg.sv
// Shared definitions for the DAC output path: default sample widths,
// the DAC midscale code and the output sequencer states.
package finalproject_pkg;

  localparam int IN_W_DEFAULT  = 13;
  localparam int OUT_W_DEFAULT = 12;

  localparam logic [11:0] DAC_MIDSCALE = 12'h800;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } state_e;

endpackage

// File: rtl/dac_sample_conditioner_sample_fifo.sv
// Small synchronous FIFO for conditioned DAC codes. A push and a pop may
// happen in the same cycle, including when the FIFO is full or holds one entry.
module sample_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [AW:0]      count_q;
  logic             doPush;
  logic             doPop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rdPtr_q];

  // A pop in the same cycle frees the slot, so a full FIFO may still accept.
  assign doPop  = pop_i && !empty_o;
  assign doPush = push_i && (!full_o || pop_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/dac_sample_conditioner.sv
// Gain, saturation and offset-binary conversion of filtered samples, buffered
// in a FIFO and released one code per DAC sync strobe.
module dac_sample_conditioner
  import finalproject_pkg::*;
#(
  parameter int IN_W        = IN_W_DEFAULT,
  parameter int OUT_W       = OUT_W_DEFAULT,
  parameter int FIFO_DEPTH  = 4,
  parameter int PRIME_LEVEL = 2
) (
  input  logic             dacSerialClock,
  input  logic             resetN,
  input  logic [IN_W-1:0]  inSample,
  input  logic             inValid,
  output logic             inReady,
  input  logic [2:0]       gainShift,
  input  logic             mute,
  input  logic             syncDAC,
  output logic [OUT_W-1:0] outCode,
  output logic             outValid,
  output logic             underrun,
  output logic [15:0]      clipCount
);

  localparam int EXT_W = IN_W + 7;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [OUT_W-1:0] MIDSCALE = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'(2**(OUT_W-1) - 1);
  localparam logic signed [EXT_W-1:0] SAT_MIN = EXT_W'(-(2**(OUT_W-1)));

  logic                    s1Valid_q;
  logic signed [EXT_W-1:0] s1Value_q;
  logic                    s2Valid_q;
  logic [OUT_W-1:0]        s2Code_q;
  logic [15:0]             clipCount_q;
  logic [OUT_W-1:0]        satVal_d;
  logic                    outOfRange_d;
  logic [OUT_W-1:0]        code_d;
  logic                    clip_d;

  state_e           state_q;
  logic [OUT_W-1:0] outCode_q;
  logic             outValid_q;
  logic             underrun_q;

  logic [OUT_W-1:0] fifoHead;
  logic             fifoFull;
  logic             fifoEmpty;
  logic [CW-1:0]    fifoCount;
  logic [CW:0]      occupancy;
  logic             accept;
  logic             pop;

  // Samples still in the pipeline already own a FIFO slot, so nothing is dropped.
  assign occupancy = (CW+1)'(fifoCount) + (CW+1)'(s1Valid_q) + (CW+1)'(s2Valid_q);
  assign inReady   = resetN && !fifoFull && (occupancy < (CW+1)'(FIFO_DEPTH));
  assign accept    = inValid && inReady;
  assign pop       = (state_q == RUN) && syncDAC && !fifoEmpty;

  always_ff @(posedge dacSerialClock or negedge resetN) begin
    if (!resetN) begin
      s1Valid_q <= 1'b0;
      s1Value_q <= '0;
    end else begin
      s1Valid_q <= accept;
      if (accept) s1Value_q <= {{7{inSample[IN_W-1]}}, inSample} << gainShift;
    end
  end

  always_comb begin
    satVal_d     = s1Value_q[OUT_W-1:0];
    outOfRange_d = 1'b0;
    if (s1Value_q > SAT_MAX) begin
      satVal_d     = SAT_MAX[OUT_W-1:0];
      outOfRange_d = 1'b1;
    end else if (s1Value_q < SAT_MIN) begin
      satVal_d     = SAT_MIN[OUT_W-1:0];
      outOfRange_d = 1'b1;
    end
    code_d = mute ? MIDSCALE : {~satVal_d[OUT_W-1], satVal_d[OUT_W-2:0]};
    clip_d = s1Valid_q && outOfRange_d && !mute;
  end

  always_ff @(posedge dacSerialClock or negedge resetN) begin
    if (!resetN) begin
      s2Valid_q   <= 1'b0;
      s2Code_q    <= '0;
      clipCount_q <= '0;
    end else begin
      s2Valid_q <= s1Valid_q;
      if (s1Valid_q) s2Code_q <= code_d;
      if (clip_d && (clipCount_q != 16'hFFFF)) clipCount_q <= clipCount_q + 1'b1;
    end
  end

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (OUT_W)
  ) u_fifo (
    .clk     (dacSerialClock),
    .rst_n   (resetN),
    .push_i  (s2Valid_q),
    .data_i  (s2Code_q),
    .pop_i   (pop),
    .data_o  (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  // An empty FIFO on a sync strobe drops back to priming to rebuild slack.
  always_ff @(posedge dacSerialClock or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      outCode_q  <= MIDSCALE;
      outValid_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: state_q <= PRIME;
        PRIME: begin
          if (fifoCount >= CW'(PRIME_LEVEL)) begin
            state_q    <= RUN;
            outValid_q <= 1'b1;
          end
        end
        RUN: begin
          if (syncDAC) begin
            if (!fifoEmpty) begin
              outCode_q <= fifoHead;
            end else begin
              underrun_q <= 1'b1;
              outValid_q <= 1'b0;
              state_q    <= PRIME;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign outCode   = outCode_q;
  assign outValid  = outValid_q;
  assign underrun  = underrun_q;
  assign clipCount = clipCount_q;

endmodule

// File: tb/tb_dac_sample_conditioner.sv
// Randomized bench for dac_sample_conditioner: a queue-based reference model
// predicts every output each cycle, with directed literal checks up front.
module tb_dac_sample_conditioner;
  import finalproject_pkg::*;

  localparam int DEPTH = 4;
  localparam int PRIME = 2;

  logic        dacSerialClock = 1'b0;
  logic        resetN;
  logic [12:0] inSample;
  logic        inValid;
  logic        inReady;
  logic [2:0]  gainShift;
  logic        mute;
  logic        syncDAC;
  logic [11:0] outCode;
  logic        outValid;
  logic        underrun;
  logic [15:0] clipCount;

  int checks = 0;
  int fails  = 0;
  bit checkEn = 0;

  dac_sample_conditioner dut (
    .dacSerialClock (dacSerialClock),
    .resetN         (resetN),
    .inSample       (inSample),
    .inValid        (inValid),
    .inReady        (inReady),
    .gainShift      (gainShift),
    .mute           (mute),
    .syncDAC        (syncDAC),
    .outCode        (outCode),
    .outValid       (outValid),
    .underrun       (underrun),
    .clipCount      (clipCount)
  );

  always #5 dacSerialClock = ~dacSerialClock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [12:0] s, input logic [2:0] g, input logic v,
                               input logic m, input logic sy);
    @(negedge dacSerialClock);
    inSample  = s;
    gainShift = g;
    inValid   = v;
    mute      = m;
    syncDAC   = sy;
  endtask

  // Reference: value times 2^gain, clamp to 12-bit signed, add 2048 for offset binary.
  function automatic logic [11:0] condition(input logic signed [12:0] s, input logic [2:0] g,
                                            input bit m, output bit clip);
    int v;
    int sat;
    v    = int'(s) * (1 << g);
    sat  = v;
    clip = 0;
    if (v > 2047) begin
      sat  = 2047;
      clip = 1;
    end else if (v < -2048) begin
      sat  = -2048;
      clip = 1;
    end
    if (m) begin
      clip = 0;
      return 12'h800;
    end
    return 12'(sat + 2048);
  endfunction

  bit                 p1v, p2v;
  logic signed [12:0] p1s;
  logic [2:0]         p1g;
  logic [11:0]        p2c;
  logic [11:0]        fifoQ[$];
  int                 mState;
  logic [11:0]        mCode;
  bit                 mValid, mUnder;
  int                 mClip;

  always @(posedge dacSerialClock or negedge resetN) begin
    int  sz;
    bit  ready, acc, clip;
    if (!resetN) begin
      p1v = 0; p2v = 0; fifoQ.delete();
      mState = 0; mCode = 12'h800; mValid = 0; mUnder = 0; mClip = 0;
    end else begin
      sz    = fifoQ.size();
      ready = (sz + int'(p1v) + int'(p2v)) < DEPTH;
      acc   = inValid && ready;
      case (mState)
        0: mState = 1;
        1: if (sz >= PRIME) begin mState = 2; mValid = 1; end
        default: begin
          if (syncDAC) begin
            if (sz > 0) mCode = fifoQ.pop_front();
            else begin mUnder = 1; mValid = 0; mState = 1; end
          end
        end
      endcase
      if (p2v) fifoQ.push_back(p2c);
      p2v = p1v;
      if (p1v) begin
        p2c = condition(p1s, p1g, mute, clip);
        if (clip && mClip < 65535) mClip++;
      end
      p1v = acc;
      if (acc) begin p1s = inSample; p1g = gainShift; end
    end
  end

  always @(negedge dacSerialClock) begin
    bit expReady;
    if (checkEn && resetN) begin
      expReady = (fifoQ.size() + int'(p1v) + int'(p2v)) < DEPTH;
      checkOutput("inReady", inReady, expReady);
      checkOutput("outCode", outCode, mCode);
      checkOutput("outValid", outValid, mValid);
      checkOutput("underrun", underrun, mUnder);
      checkOutput("clipCount", clipCount, mClip);
    end
  end

  initial begin
    resetN = 1; inSample = '0; gainShift = '0; inValid = 0; mute = 0; syncDAC = 0;
    #2 resetN = 0;
    repeat (2) @(negedge dacSerialClock);
    checkOutput("rst inReady", inReady, 0);
    checkOutput("rst outCode", outCode, DAC_MIDSCALE);
    checkOutput("rst outValid", outValid, 0);
    checkOutput("rst underrun", underrun, 0);
    checkOutput("rst clipCount", clipCount, 0);
    @(negedge dacSerialClock);
    resetN  = 1;
    checkEn = 1;

    applyStimulus(13'h0100, 3'd0, 1, 0, 0);
    applyStimulus(13'h1F00, 3'd0, 1, 0, 0);
    applyStimulus(13'h0000, 3'd0, 0, 0, 0);
    repeat (5) @(negedge dacSerialClock);
    checkOutput("primed outValid", outValid, 1);
    applyStimulus(13'h0000, 3'd0, 0, 0, 1);
    applyStimulus(13'h0000, 3'd0, 0, 0, 0);
    checkOutput("pop +256", outCode, 12'h900);
    applyStimulus(13'h0000, 3'd0, 0, 0, 1);
    applyStimulus(13'h0000, 3'd0, 0, 0, 0);
    checkOutput("pop -256", outCode, 12'h700);

    applyStimulus(13'h0200, 3'd3, 1, 0, 0);
    applyStimulus(13'h1C00, 3'd3, 1, 0, 0);
    applyStimulus(13'h0000, 3'd0, 0, 0, 0);
    repeat (4) @(negedge dacSerialClock);
    applyStimulus(13'h0000, 3'd0, 0, 0, 1);
    applyStimulus(13'h0000, 3'd0, 0, 0, 0);
    checkOutput("clip high", outCode, 12'hFFF);
    applyStimulus(13'h0000, 3'd0, 0, 0, 1);
    applyStimulus(13'h0000, 3'd0, 0, 0, 0);
    checkOutput("clip low", outCode, 12'h000);
    checkOutput("clip count", clipCount, 16'd2);

    applyStimulus(13'h0FFF, 3'd7, 1, 1, 0);
    applyStimulus(13'h0000, 3'd0, 0, 1, 0);
    applyStimulus(13'h0000, 3'd0, 0, 1, 0);
    applyStimulus(13'h0000, 3'd0, 0, 0, 0);
    repeat (3) @(negedge dacSerialClock);
    applyStimulus(13'h0000, 3'd0, 0, 0, 1);
    applyStimulus(13'h0000, 3'd0, 0, 0, 0);
    checkOutput("mute code", outCode, 12'h800);
    checkOutput("mute no clip", clipCount, 16'd2);

    for (int i = 0; i < 8; i++) applyStimulus(13'($urandom()), 3'($urandom_range(0, 2)), 1, 0, 0);
    checkOutput("full inReady", inReady, 0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(13'($urandom()), 3'($urandom_range(0, 2)), 1, 0, 1);
      applyStimulus(13'($urandom()), 3'($urandom_range(0, 2)), 1, 0, 0);
    end

    for (int i = 0; i < 10; i++) applyStimulus(13'h0000, 3'd0, 0, 0, 1);
    applyStimulus(13'h0000, 3'd0, 0, 0, 0);
    checkOutput("underrun set", underrun, 1);
    checkOutput("underrun outValid", outValid, 0);

    for (int i = 0; i < 3; i++) applyStimulus(13'($urandom()), 3'd7, 1, 0, 0);
    applyStimulus(13'h0000, 3'd0, 0, 0, 0);
    repeat (3) @(negedge dacSerialClock);
    #2 resetN = 0;
    #1;
    checkOutput("midrst outCode", outCode, 12'h800);
    checkOutput("midrst outValid", outValid, 0);
    checkOutput("midrst clipCount", clipCount, 0);
    checkOutput("midrst underrun", underrun, 0);
    checkOutput("midrst inReady", inReady, 0);
    @(negedge dacSerialClock);
    resetN = 1;

    for (int i = 0; i < 2000; i++) begin
      applyStimulus(13'($urandom()), 3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0));
      if (i == 1000) begin
        #2 resetN = 0;
        @(negedge dacSerialClock);
        resetN = 1;
      end
    end
    applyStimulus(13'h0000, 3'd0, 0, 0, 0);
    repeat (2) @(negedge dacSerialClock);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/dac_sample_conditioner.md
# dac_sample_conditioner

Conditions the filtered audio sample stream on its way to the DAC serializer: applies a programmable power-of-two gain, saturates to the DAC range, converts two's complement to offset-binary DAC code and buffers results in a small FIFO. It sits directly downstream of the high-pass filter and directly upstream of the DAC packaging block. It releases exactly one code per DAC sync pulse, absorbing jitter between filter output timing and the DAC frame.

## Interface
Parameters:
- IN_W, 13, width of signed two's-complement input sample
- OUT_W, 12, width of DAC code (offset binary)
- FIFO_DEPTH, 4, FIFO entries (power of two, ≥2)
- PRIME_LEVEL, 2, FIFO fill required before output starts

Ports:
- dacSerialClock  in  1  sole clock (DAC serial clock domain)
- resetN  in  1  reset, asynchronous, active-low
- inSample  in  IN_W  signed sample from filter
- inValid  in  1  inSample valid this cycle
- inReady  out  1  block can accept a sample this cycle
- gainShift  in  3  left-shift amount 0..7, sampled with each accepted sample
- mute  in  1  forces midscale code for samples processed while high
- syncDAC  in  1  single-cycle DAC frame strobe; requests one code
- outCode  out  OUT_W  code presented to DAC block
- outValid  out  1  high while in RUN state
- underrun  out  1  sticky; syncDAC arrived with FIFO empty in RUN
- clipCount  out  16  saturating count of clipped samples

## Operation
- Transfer occurs when inValid && inReady. inReady = (fifoCount + inFlight) < FIFO_DEPTH, where inFlight counts samples in the 2-stage pipeline; no sample is ever dropped.
- Stage 1: sign-extend inSample to IN_W+7 bits, shift left by gainShift.
- Stage 2: saturate to signed OUT_W range [-2048, 2047]; clip flag if value out of range; code = saturated value with MSB inverted; if mute (sampled at stage 2) code = 12'h800. Clip increments clipCount (stops at 16'hFFFF); muted samples never count as clipped.
- Stage 2 result is written to FIFO.
- State machine:
  - IDLE: after reset; outCode = 12'h800; goes to PRIME next cycle.
  - PRIME: syncDAC ignored (no pop); outCode holds; → RUN when fifoCount ≥ PRIME_LEVEL.
  - RUN: on syncDAC, if FIFO non-empty pop head into outCode; if empty, hold outCode, set underrun, → PRIME.
- Push and pop in the same cycle allowed; count unchanged, data order preserved, including full and single-entry cases.
- underrun clears only on reset.
- Reset asserted mid-operation: FIFO, pipeline, counters flushed; outputs return to reset values immediately (asynchronous).

## Timing
- Reset values: inReady 0 while resetN low, 1 from first cycle after release; outCode 12'h800; outValid 0; underrun 0; clipCount 0; state IDLE.
- Sample accepted cycle N → in FIFO at end of N+2, poppable from N+3.
- syncDAC at cycle M in RUN with non-empty FIFO → new outCode valid from M+1, stable until next pop.
- Registered outputs only; no combinational path from syncDAC to outCode.
- Back-to-back inputs sustain one sample/cycle until full; inReady drops in the cycle the occupancy reaches FIFO_DEPTH.

## Structure
- Shared package finalproject_pkg: IN_W/OUT_W defaults, DAC_MIDSCALE = 12'h800, state enum {IDLE, PRIME, RUN}.
- One sub-module: sample_fifo (synchronous FIFO, depth/width parameters, push/pop/full/empty/count, simultaneous push-pop support).
- Gain/saturate/convert pipeline and state machine live in the top module.

## Test plan
- Reset, gainShift=0, push 13'sh0100 then 13'sh1F00 (−256), two syncDAC pulses → outCode 12'h900 then 12'h700; outValid rises once fifoCount reaches 2.
- gainShift=3, push 13'sh0200 (512·8=4096) and 13'sh1C00 (−1024·8) → codes 12'hFFF and 12'h000, clipCount = 2.
- mute high, push 13'sh0FFF with gainShift=7 → code 12'h800, clipCount unchanged.
- Hold inValid high, no syncDAC → exactly 4 accepted, inReady low; one syncDAC with inValid still high → one pop and one new accept, order preserved over 8 pops.
- In RUN, drain FIFO then pulse syncDAC → outCode holds last value, underrun=1, outValid=0 until 2 new samples, underrun stays 1.
- Assert resetN low mid-stream with 3 entries queued → outCode 12'h800, outValid 0, clipCount 0 immediately; after release first pop returns only post-reset data.
